// File: rtl/inv_sub_bytes_iter.sv
// Iterative AES inverse SubBytes stage. Takes one 128-bit state block,
// substitutes BPC bytes per clock in place, and hands the finished block
// downstream over a valid/ready handshake. One block is in flight at a time.
module inv_sub_bytes_iter #(
    parameter int BPC = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [0:127] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [0:127] out_data,
    output logic         busy
);
    localparam int NBEATS = 16 / BPC;
    localparam logic [3:0] LAST_BEAT = 4'(NBEATS - 1);

    generate
        if (BPC != 1 && BPC != 2 && BPC != 4 && BPC != 8 && BPC != 16) begin : gBadBpc
            $error("inv_sub_bytes_iter: BPC must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    // FIPS-197 inverse S-box, entry n at bits [8n +: 8].
    localparam logic [0:2047] INV_SBOX = {
        128'h52096ad53036a538bf40a39e81f3d7fb,
        128'h7ce339829b2fff87348e4344c4dee9cb,
        128'h547b9432a6c2233dee4c950b42fac34e,
        128'h082ea16628d924b2765ba2496d8bd125,
        128'h72f8f66486689816d4a45ccc5d65b692,
        128'h6c704850fdedb9da5e154657a78d9d84,
        128'h90d8ab008cbcd30af7e45805b8b34506,
        128'hd02c1e8fca3f0f02c1afbd0301138a6b,
        128'h3a9111414f67dcea97f2cfcef0b4e673,
        128'h96ac7422e7ad3585e2f937e81c75df6e,
        128'h47f11a711d29c5896fb7620eaa18be1b,
        128'hfc563e4bc6d279209adbc0fe78cd5af4,
        128'h1fdda8338807c731b11210592780ec5f,
        128'h60517fa919b54a0d2de57a9f93c99cef,
        128'ha0e03b4dae2af5b0c8ebbb3c83539961,
        128'h172b047eba77d626e169146355210c7d
    };

    function automatic logic [7:0] invSbox(input logic [7:0] b);
        return INV_SBOX[{b, 3'b000} +: 8];
    endfunction

    typedef enum logic [1:0] {
        IDLE,
        PROC,
        DONE
    } fsmState_e;

    fsmState_e    state;
    fsmState_e    nextState;
    logic [0:127] workReg;
    logic [0:127] nextWork;
    logic [3:0]   cnt;
    logic [6:0]   bitPos;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    // Next-state decode and handshake outputs.
    always_comb begin
        nextState = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b0;
        unique case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) nextState = PROC;
            end
            PROC: begin
                busy = 1'b1;
                if (cnt == LAST_BEAT) nextState = DONE;
            end
            DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
                if (out_ready) nextState = IDLE;
            end
            default: nextState = IDLE;
        endcase
    end

    // Substitute the BPC bytes addressed by the current beat; the rest pass through.
    always_comb begin
        nextWork = workReg;
        bitPos   = '0;
        for (int j = 0; j < BPC; j++) begin
            bitPos = 7'((int'(cnt) * BPC + j) * 8);
            nextWork[bitPos +: 8] = invSbox(workReg[bitPos +: 8]);
        end
    end

    // Working register and beat counter: load on accept, update in place while processing.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            workReg <= '0;
            cnt     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        workReg <= in_data;
                        cnt     <= '0;
                    end
                end
                PROC: begin
                    workReg <= nextWork;
                    cnt     <= cnt + 4'd1;
                end
                default: ;
            endcase
        end
    end

    assign out_data = workReg;

endmodule

// File: tb/tb_inv_sub_bytes_iter.sv
// Bench for inv_sub_bytes_iter: one instance per legal BPC, a cycle-level
// reference model computing the inverse S-box by GF(2^8) arithmetic, a
// per-cycle compare process, and directed vectors with literal expectations.
module tb_inv_sub_bytes_iter;

    logic         clk = 1'b0;
    logic         rstN = 1'b0;
    logic         inValid  [5];
    logic         outReady [5];
    logic [0:127] inData   [5];
    logic         inReadyW [5];
    logic         outValidW[5];
    logic         busyW    [5];
    logic [0:127] outDataW [5];

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    bit           mBusy[5] = '{default: 1'b0};
    int           mDue [5] = '{default: 0};
    logic [127:0] mExp [5] = '{default: '0};

    localparam logic [127:0] C1_IN  = 128'h7a9f102789d5f50b2beffd9f3dca4ea7;
    localparam logic [127:0] C1_OUT = 128'hbd6e7c3df2b5779e0b61216e8b10b689;
    localparam logic [127:0] SPOT_IN  = 128'h7ced16637ced16637ced16637ced1663;
    localparam logic [127:0] SPOT_OUT = 128'h0153ff000153ff000153ff000153ff00;
    localparam logic [127:0] ALL63  = 128'h63636363636363636363636363636363;
    localparam logic [127:0] ALL52  = 128'h52525252525252525252525252525252;

    always #5 clk = ~clk;

    for (genvar g = 0; g < 5; g++) begin : gDut
        inv_sub_bytes_iter #(.BPC(1 << g)) u (
            .clk      (clk),
            .rst_n    (rstN),
            .in_valid (inValid[g]),
            .in_ready (inReadyW[g]),
            .in_data  (inData[g]),
            .out_valid(outValidW[g]),
            .out_ready(outReady[g]),
            .out_data (outDataW[g]),
            .busy     (busyW[g])
        );
    end

    // ---------------- reference arithmetic ----------------
    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int i = 0; i < 8; i++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    // Inverse affine transform, then x^254 (= x^-1, and 0 -> 0).
    function automatic logic [7:0] invByte(input logic [7:0] v);
        logic [7:0] y = rotl(v, 1) ^ rotl(v, 3) ^ rotl(v, 6) ^ 8'h05;
        logic [7:0] r = 8'h01;
        for (int i = 0; i < 254; i++) r = gmul(r, y);
        return r;
    endfunction

    function automatic logic [127:0] modelBlock(input logic [0:127] b);
        logic [0:127] o;
        for (int i = 0; i < 16; i++) o[8*i +: 8] = invByte(b[8*i +: 8]);
        return o;
    endfunction

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chkBit(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkInt(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // ---------------- cycle model ----------------
    // One block per instance: accepted when idle and valid, due NBEATS edges later,
    // retired on the first edge after that with out_ready high.
    always @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int g = 0; g < 5; g++) begin
                mBusy[g] = 1'b0;
                mExp[g]  = '0;
            end
        end else begin
            cyc = cyc + 1;
            for (int g = 0; g < 5; g++) begin
                if (!mBusy[g]) begin
                    if (inValid[g]) begin
                        mBusy[g] = 1'b1;
                        mExp[g]  = modelBlock(inData[g]);
                        mDue[g]  = cyc + (16 >> g);
                    end
                end else if (cyc > mDue[g] && outReady[g]) begin
                    mBusy[g] = 1'b0;
                end
            end
        end
    end

    // Compare every instance against the model on each falling edge.
    always @(negedge clk) begin
        for (int g = 0; g < 5; g++) begin
            if (!rstN) begin
                chkBit($sformatf("rst inReady[%0d]", g), inReadyW[g], 1'b1);
                chkBit($sformatf("rst outValid[%0d]", g), outValidW[g], 1'b0);
                chkBit($sformatf("rst busy[%0d]", g), busyW[g], 1'b0);
                chk($sformatf("rst outData[%0d]", g), outDataW[g], '0);
            end else begin
                chkBit($sformatf("outValid[%0d]", g), outValidW[g], mBusy[g] && (cyc >= mDue[g]));
                chkBit($sformatf("inReady[%0d]", g), inReadyW[g], !mBusy[g]);
                chkBit($sformatf("busy[%0d]", g), busyW[g], mBusy[g]);
                if (mBusy[g] && cyc >= mDue[g])
                    chk($sformatf("outData[%0d]", g), outDataW[g], mExp[g]);
            end
        end
    end

    // ---------------- stimulus ----------------
    // Entered and left just after a rising edge; returns the accepting edge index.
    task automatic acceptBlock(input int g, input logic [0:127] d, input bit keep,
                               output int acceptCyc);
        bit got = 1'b0;
        acceptCyc = -1;
        inValid[g] = 1'b1;
        inData[g]  = d;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (inReadyW[g]) got = 1'b1;
            @(posedge clk);
            #1;
            if (got) acceptCyc = cyc;
        end
        if (!keep) inValid[g] = 1'b0;
        if (!got) chkBit($sformatf("accept timeout[%0d]", g), 1'b0, 1'b1);
    endtask

    // Returns at the falling edge where out_valid is first seen high.
    task automatic waitOut(input int g, output int seenCyc);
        bit got = 1'b0;
        seenCyc = -1;
        for (int t = 0; t < 100 && !got; t++) begin
            @(negedge clk);
            if (outValidW[g]) begin
                got = 1'b1;
                seenCyc = cyc;
            end
        end
        if (!got) chkBit($sformatf("out timeout[%0d]", g), 1'b0, 1'b1);
    endtask

    task automatic runBlock(input int g, input logic [0:127] d, input logic [127:0] expOut,
                            input string name);
        int acc;
        int seen;
        acceptBlock(g, d, 1'b0, acc);
        waitOut(g, seen);
        chkInt($sformatf("latency %s bpc%0d", name, 1 << g), seen - acc, 16 >> g);
        chk($sformatf("data %s bpc%0d", name, 1 << g), outDataW[g], expOut);
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic [0:127] d;
        logic [127:0] held;
        int acc;
        int accB;
        int seen;

        for (int g = 0; g < 5; g++) begin
            inValid[g]  = 1'b0;
            outReady[g] = 1'b1;
            inData[g]   = '0;
        end
        repeat (3) @(posedge clk);
        #1 rstN = 1'b1;

        // Pin the model to hand-computed FIPS-197 values.
        chk("model 7c", 128'(invByte(8'h7c)), 128'h01);
        chk("model ed", 128'(invByte(8'hed)), 128'h53);
        chk("model 16", 128'(invByte(8'h16)), 128'hff);
        chk("model 00", 128'(invByte(8'h00)), 128'h52);
        chk("model C1", modelBlock(C1_IN), C1_OUT);

        @(posedge clk);
        #1;

        // Directed blocks and a full 256-value sweep on every BPC.
        for (int g = 0; g < 5; g++) begin
            runBlock(g, '0, ALL52, "zero");
            runBlock(g, ALL63, '0, "all63");
            runBlock(g, C1_IN, C1_OUT, "c1");
            runBlock(g, SPOT_IN, SPOT_OUT, "spot");
            for (int blk = 0; blk < 16; blk++) begin
                for (int i = 0; i < 16; i++) d[8*i +: 8] = 8'(blk * 16 + i);
                acceptBlock(g, d, 1'b0, acc);
                waitOut(g, seen);
                @(posedge clk);
                #1;
            end
        end

        // Backpressure on BPC=4: output frozen, input ignored, idle right after release.
        outReady[2] = 1'b0;
        acceptBlock(2, C1_IN, 1'b0, acc);
        waitOut(2, seen);
        held = outDataW[2];
        chk("stall first data", held, C1_OUT);
        for (int t = 0; t < 10; t++) begin
            @(posedge clk);
            #1;
            inValid[2] = 1'b1;
            inData[2]  = {$urandom, $urandom, $urandom, $urandom};
            @(negedge clk);
            chk("stall data", outDataW[2], held);
            chkBit("stall inReady", inReadyW[2], 1'b0);
        end
        @(posedge clk);
        #1;
        inValid[2]  = 1'b0;
        outReady[2] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chkBit("release outValid", outValidW[2], 1'b0);
        chkBit("release inReady", inReadyW[2], 1'b1);
        @(posedge clk);
        #1;

        // Back-to-back with in_valid held; data changes after the first accept.
        acceptBlock(2, ALL63, 1'b1, acc);
        inData[2] = C1_IN;
        acceptBlock(2, C1_IN, 1'b0, accB);
        chkInt("b2b accept gap", accB - acc, 6);
        waitOut(2, seen);
        chk("b2b second data", outDataW[2], C1_OUT);
        @(posedge clk);
        #1;

        // Asynchronous reset in the middle of processing.
        acceptBlock(2, C1_IN, 1'b0, acc);
        @(posedge clk);
        #2 rstN = 1'b0;
        #1;
        chkBit("midrst outValid", outValidW[2], 1'b0);
        chkBit("midrst inReady", inReadyW[2], 1'b1);
        chkBit("midrst busy", busyW[2], 1'b0);
        chk("midrst outData", outDataW[2], '0);
        @(posedge clk);
        #1 rstN = 1'b1;
        runBlock(2, '0, ALL52, "postrst");
        runBlock(0, C1_IN, C1_OUT, "postrst");

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/inv_sub_bytes_iter.md
Name: inv_sub_bytes_iter

Overview:
- Iterative AES inverse SubBytes stage. It sits directly downstream of the inverse ShiftRows stage in the decryption datapath.
- Accepts one 128-bit state block over a valid/ready handshake.
- Substitutes BPC bytes per clock through the inverse S-box. Presents the substituted block over a valid/ready output handshake.
- Trades area (BPC S-box instances) against latency (16/BPC cycles).

Parameters:
- BPC, 4, bytes substituted per clock. Legal values: 1, 2, 4, 8, 16. Any other value is an elaboration error.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream has a state block on in_data.
- in_ready  output  1  block can accept; high only in IDLE.
- in_data  input  [0:127]  state block. Byte i is bits [8i:8i+7], i=0..15, column-major (byte 0 = row0/col0, byte 4 = row0/col1).
- out_valid  output  1  out_data holds a completed result.
- out_ready  input  1  downstream accepts the result.
- out_data  output  [0:127]  substituted block, same byte ordering as in_data.
- busy  output  1  high in PROC or DONE.

Behaviour:
- Reset (asynchronous assert, synchronous-clean deassert handled externally):
  - state=IDLE, working register=0, beat counter=0.
  - out_valid=0, out_data=128'h0, busy=0, in_ready=1.
- States: IDLE, PROC, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready at a rising edge: in_data loads into the working register, counter=0, go to PROC.
- PROC:
  - Each cycle replaces bytes [cnt*BPC .. cnt*BPC+BPC-1] of the working register in place with InvSbox(byte). Counter increments.
  - Byte order is ascending, byte 0 first.
  - After beat NBEATS-1 (NBEATS=16/BPC), go to DONE.
- DONE:
  - out_valid=1. out_data is stable until the handshake.
  - On out_valid&&out_ready, go to IDLE and drop out_valid the next cycle.
  - Holding out_ready low stalls indefinitely with no change to out_data.
- Latency:
  - Handshake at edge k, then out_valid rises after edge k+NBEATS.
  - BPC=4: 4 cycles. BPC=16: 1 cycle. BPC=1: 16 cycles.
- Throughput:
  - One block per NBEATS+2 cycles minimum. in_ready is low in PROC and DONE, so there is no overlap.
  - in_valid while not ready is ignored and not latched.
- out_data always drives the working register. Its contents are meaningful only while out_valid=1.
- Inverse S-box:
  - Pure combinational function, FIPS-197 inverse S-box: inverse affine transform, then multiplicative inverse in GF(2^8) modulo x^8+x^4+x^3+x+1, with 0 mapping to 0.
  - Realisation is either a 256-entry table or field arithmetic; it must be bit-exact to FIPS-197.
- Reset asserted mid-PROC or mid-DONE aborts immediately. The partial block is discarded and all registers return to reset values.
- in_data is sampled only at the accepting edge. Later changes to in_data do not affect the block in flight.

Test Plan:
- Reset check: assert rst_n=0 mid-PROC -> out_valid=0, out_data=0, in_ready=1 immediately (asynchronous). The next accepted block completes correctly.
- Constant bytes: in_data=128'h0 -> out_data=128'h52525252525252525252525252525252. in_data=all bytes 0x63 -> out_data=128'h0.
- FIPS-197 C.1 round 1: in_data=128'h7a9f102789d5f50b2beffd9f3dca4ea7 -> out_data=128'hbd6e7c3df2b5779e0b61216e8b10b689.
- Latency, repeated for each legal BPC: accept at edge k -> out_valid first seen high after edge k+16/BPC.
  - Spot bytes: 0x7C->0x01, 0xED->0x53, 0x16->0xFF.
- Backpressure: hold out_ready=0 for 10 cycles after out_valid -> out_data unchanged, in_ready=0 throughout.
  - Changing in_valid/in_data meanwhile has no effect.
  - Release out_ready -> IDLE next cycle.
- Back-to-back: two blocks with in_valid held high -> second accepted on the first cycle in_ready returns to 1. Both results correct and in order.
